// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage with a single-cycle ALU, branch resolution and a 32-iteration shift-add multiplier.
module exe_stage #(
    parameter int len = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [len-1:0] pc,
    input  logic           wb_en,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic           flush,
    input  logic [1:0]     branch_type,
    input  logic [3:0]     exe_cmd,
    input  logic [31:0]    reg2,
    input  logic [31:0]    alu_inp1,
    input  logic [31:0]    alu_inp2,
    input  logic [4:0]     dest,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic           mem_write_out,
    output logic [31:0]    alu_result,
    output logic [31:0]    reg2_out,
    output logic [4:0]     dest_out,
    output logic           branch_taken,
    output logic [len-1:0] branch_addr,
    output logic           exe_stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [31:0] mcand, mplier, product, alu_comb, offset;
    logic [4:0]  count;
    logic        issue, cond, mask;
    assign issue = state == IDLE && exe_cmd == 4'b1100 && !flush && !reset;
    assign exe_stall = !reset && (issue || state == BUSY);
    assign mask = flush || exe_stall || reset;
    assign wb_en_out = wb_en && !mask;
    assign mem_read_out = mem_read && !mask;
    assign mem_write_out = mem_write && !mask;
    assign reg2_out = reg2;
    assign dest_out = dest;
    assign cond = branch_type == 2'b11 ||
                  (branch_type == 2'b01 && alu_inp1 == 32'd0) ||
                  (branch_type == 2'b10 && alu_inp1 != reg2);
    assign branch_taken = cond && !mask;
    assign offset = alu_inp2 << 2;
    assign branch_addr = pc + offset[len-1:0];
    always_comb begin
        alu_comb = 32'd0;
        case (exe_cmd)
            4'b0000: alu_comb = alu_inp1 + alu_inp2;
            4'b0010: alu_comb = alu_inp1 - alu_inp2;
            4'b0100: alu_comb = alu_inp1 & alu_inp2;
            4'b0101: alu_comb = alu_inp1 | alu_inp2;
            4'b0110: alu_comb = ~(alu_inp1 | alu_inp2);
            4'b0111: alu_comb = alu_inp1 ^ alu_inp2;
            4'b1000: alu_comb = alu_inp1 << alu_inp2[4:0];
            4'b1001: alu_comb = $signed(alu_inp1) >>> alu_inp2[4:0];
            4'b1010: alu_comb = alu_inp1 >> alu_inp2[4:0];
            default: alu_comb = 32'd0;
        endcase
    end
    // The product is only presented in DONE; MUL in other states reads as 0 via the default arm.
    assign alu_result = state == DONE ? product : alu_comb;
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            product <= 32'd0;
            count   <= 5'd0;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    mcand   <= alu_inp1;
                    mplier  <= alu_inp2;
                    product <= 32'd0;
                    count   <= 5'd0;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (mplier[0]) product <= product + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized self-checking bench for exe_stage against a behavioural model.
module tb_exe_stage;
    logic        clock = 0, reset = 1;
    logic [31:0] pc = 0, reg2 = 0, alu_inp1 = 0, alu_inp2 = 0;
    logic        wb_en = 0, mem_read = 0, mem_write = 0, flush = 0;
    logic [1:0]  branch_type = 0;
    logic [3:0]  exe_cmd = 0;
    logic [4:0]  dest = 0;
    logic        wb_en_out, mem_read_out, mem_write_out, branch_taken, exe_stall;
    logic [31:0] alu_result, reg2_out, branch_addr;
    logic [4:0]  dest_out;
    int total = 0, bad = 0;

    exe_stage #(.len(32)) dut (
        .clock(clock), .reset(reset), .pc(pc), .wb_en(wb_en), .mem_read(mem_read),
        .mem_write(mem_write), .flush(flush), .branch_type(branch_type), .exe_cmd(exe_cmd),
        .reg2(reg2), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .dest(dest),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .alu_result(alu_result), .reg2_out(reg2_out), .dest_out(dest_out),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .exe_stall(exe_stall)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        int s;
        s = int'(b % 32);
        p = longint'(a) * longint'(b);
        case (c)
            4'd0: return a + b;
            4'd2: return a - b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return ~(a | b);
            4'd7: return a ^ b;
            4'd8: return a << s;
            4'd9: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd10: return a >> s;
            4'd12: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; exe_cmd = 0; branch_type = 2'b11; wb_en = 1; mem_read = 1; mem_write = 1;
        step;
        @(negedge clock);
        total++;
        if ({exe_stall, branch_taken, wb_en_out, mem_read_out, mem_write_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000", {exe_stall, branch_taken, wb_en_out, mem_read_out, mem_write_out});
        end
        step;
        reset = 0; branch_type = 0; mem_read = 0; mem_write = 0;
    endtask

    task automatic test_alu_directed;
        logic [31:0] want [4];
        logic [31:0] got  [4];
        logic [3:0]  cmds [4];
        logic [31:0] b2   [4];
        cmds = '{4'b0000, 4'b1001, 4'b1010, 4'b1010};
        b2   = '{32'h1, 32'd4, 32'd4, 32'h24};
        want = '{32'h8000_0000, 32'hFF00_0000, 32'h0F00_0000, 32'h0F00_0000};
        for (int i = 0; i < 4; i++) begin
            step;
            exe_cmd = cmds[i]; wb_en = 1; flush = 0; branch_type = 0;
            alu_inp1 = (i == 0) ? 32'h7FFF_FFFF : 32'hF000_0000; alu_inp2 = b2[i];
            @(negedge clock);
            got[i] = alu_result;
            total++;
            if (got[i] !== want[i] || exe_stall !== 1'b0 || wb_en_out !== 1'b1) begin
                bad++;
                $display("FAIL alu_directed[%0d] got=%h stall=%b wb=%b want=%h stall=0 wb=1", i, got[i], exe_stall, wb_en_out, want[i]);
            end
        end
    endtask

    task automatic test_alu_random;
        logic [3:0] codes [15];
        logic [31:0] w;
        codes = '{0, 2, 4, 5, 6, 7, 8, 9, 10, 1, 3, 11, 13, 14, 15};
        for (int i = 0; i < 60; i++) begin
            step;
            exe_cmd = codes[$urandom_range(0, 14)];
            alu_inp1 = $urandom; alu_inp2 = $urandom;
            if (i % 4 == 0) alu_inp2 = $urandom_range(0, 40);
            reg2 = $urandom; dest = 5'($urandom);
            wb_en = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            flush = 0; branch_type = 0;
            @(negedge clock);
            w = alu_ref(exe_cmd, alu_inp1, alu_inp2);
            total++;
            if (alu_result !== w || exe_stall !== 1'b0 || reg2_out !== reg2 || dest_out !== dest ||
                {wb_en_out, mem_read_out, mem_write_out} !== {wb_en, mem_read, mem_write}) begin
                bad++;
                $display("FAIL alu_random cmd=%h got=%h stall=%b en=%b want=%h en=%b",
                         exe_cmd, alu_result, exe_stall, {wb_en_out, mem_read_out, mem_write_out}, w, {wb_en, mem_read, mem_write});
            end
        end
    endtask

    task automatic test_branch;
        logic t;
        logic [31:0] a;
        step;
        exe_cmd = 0; branch_type = 2'b10; alu_inp1 = 5; reg2 = 6; pc = 32'h100; alu_inp2 = 32'hFFFF_FFFE;
        wb_en = 1; mem_read = 1; mem_write = 1; flush = 0;
        @(negedge clock);
        total++;
        if (branch_taken !== 1'b1 || branch_addr !== 32'hF8) begin
            bad++;
            $display("FAIL bne_taken got taken=%b addr=%h want taken=1 addr=000000f8", branch_taken, branch_addr);
        end
        step;
        flush = 1;
        @(negedge clock);
        total++;
        if ({branch_taken, wb_en_out, mem_read_out, mem_write_out} !== 4'b0) begin
            bad++;
            $display("FAIL bne_flush got=%b want=0000", {branch_taken, wb_en_out, mem_read_out, mem_write_out});
        end
        for (int i = 0; i < 40; i++) begin
            step;
            branch_type = 2'($urandom); flush = ($urandom_range(0, 3) == 0);
            alu_inp1 = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            reg2 = ($urandom_range(0, 2) == 0) ? alu_inp1 : $urandom;
            alu_inp2 = $urandom; pc = $urandom; exe_cmd = 4'd4;
            @(negedge clock);
            t = !flush && (branch_type == 3 || (branch_type == 1 && alu_inp1 == 0) || (branch_type == 2 && alu_inp1 != reg2));
            a = pc + alu_inp2 * 4;
            total++;
            if (branch_taken !== t || branch_addr !== a) begin
                bad++;
                $display("FAIL branch_random bt=%0d got taken=%b addr=%h want taken=%b addr=%h", branch_type, branch_taken, branch_addr, t, a);
            end
        end
        flush = 0; branch_type = 0;
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input bit flush_mid);
        int n;
        logic [31:0] w;
        w = alu_ref(4'd12, a, b);
        step;
        exe_cmd = 4'b1100; alu_inp1 = a; alu_inp2 = b; wb_en = 1; flush = 0; branch_type = 0;
        @(negedge clock);
        n = 0;
        while (exe_stall === 1'b1 && n < 100) begin
            n++;
            total++;
            if (wb_en_out !== 1'b0) begin
                bad++;
                $display("FAIL mul_stall_wb cycle=%0d got=%b want=0", n, wb_en_out);
            end
            step;
            alu_inp1 = $urandom; alu_inp2 = $urandom;
            if (flush_mid) flush = 1'($urandom);
            @(negedge clock);
        end
        if (flush_mid) begin
            flush = 0;
            #1;
        end
        total++;
        if (n !== 33 || alu_result !== w || wb_en_out !== 1'b1 || exe_stall !== 1'b0) begin
            bad++;
            $display("FAIL mul %h*%h got stall_cycles=%0d result=%h wb=%b want 33 %h wb=1", a, b, n, alu_result, wb_en_out, w);
        end
    endtask

    task automatic test_back_to_back;
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        test_mul(32'd3, 32'd4, 0);
    endtask

    task automatic test_flush_blocks_issue;
        step;
        exe_cmd = 4'b1100; alu_inp1 = 7; alu_inp2 = 9; flush = 1; wb_en = 1;
        @(negedge clock);
        total++;
        if (exe_stall !== 1'b0 || wb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL mul_flushed_issue got stall=%b wb=%b want 0 0", exe_stall, wb_en_out);
        end
        step;
        exe_cmd = 0; flush = 0;
        @(negedge clock);
        total++;
        if (exe_stall !== 1'b0 || alu_result !== 32'd16) begin
            bad++;
            $display("FAIL after_flushed_mul got stall=%b result=%h want 0 00000010", exe_stall, alu_result);
        end
    endtask

    task automatic test_reset_mid_busy;
        step;
        exe_cmd = 4'b1100; alu_inp1 = 123; alu_inp2 = 456; wb_en = 1; branch_type = 0;
        for (int i = 0; i < 10; i++) step;
        reset = 1; branch_type = 2'b11;
        @(negedge clock);
        total++;
        if ({exe_stall, branch_taken, wb_en_out} !== 3'b0) begin
            bad++;
            $display("FAIL reset_mid_busy got stall/taken/wb=%b want 000", {exe_stall, branch_taken, wb_en_out});
        end
        step;
        reset = 0; branch_type = 0; exe_cmd = 0; alu_inp1 = 2; alu_inp2 = 3;
        @(negedge clock);
        total++;
        if (exe_stall !== 1'b0 || alu_result !== 32'd5 || wb_en_out !== 1'b1) begin
            bad++;
            $display("FAIL add_after_reset got stall=%b result=%h wb=%b want 0 00000005 1", exe_stall, alu_result, wb_en_out);
        end
        step;
        @(negedge clock);
        total++;
        if (exe_stall !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got stall=%b want 0", exe_stall);
        end
    endtask

    initial begin
        test_reset;
        test_alu_directed;
        test_alu_random;
        test_branch;
        test_mul(32'h0001_0003, 32'h0000_0005, 0);
        test_back_to_back;
        test_mul($urandom, $urandom, 1);
        test_mul($urandom, $urandom, 0);
        test_flush_blocks_issue;
        test_reset_mid_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ID/EXE pipeline register and feeds the EXE/MEM register.
- Performs single-cycle ALU operations, resolves branches and computes branch targets.
- Runs a 32-iteration shift-add multiplier for MUL. While MUL is in progress it raises exe_stall, which freezes PC, IF/ID and ID/EXE, and injects bubbles downstream.

Parameters:
len, 32, width of pc / pc_out / branch_addr

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
pc  input  len  PC+4 of the instruction in EXE
wb_en, mem_read, mem_write  input  1 each  control bits from ID/EXE
flush  input  1  instruction in EXE is squashed (bubble)
branch_type  input  2  00 none, 01 BEZ, 10 BNE, 11 JMP
exe_cmd  input  4  operation select
reg2  input  32  store data / BNE comparand
alu_inp1, alu_inp2  input  32 each  operands
dest  input  5  destination register
wb_en_out, mem_read_out, mem_write_out  output  1 each  to EXE/MEM
alu_result  output  32  to EXE/MEM
reg2_out  output  32  reg2 passthrough
dest_out  output  5  dest passthrough
branch_taken  output  1  to IF PC mux and flush logic
branch_addr  output  len  branch/jump target
exe_stall  output  1  freeze upstream stages

Behaviour:
- Clocking: one clock (clock); reset is synchronous and active-high (reset).
- exe_cmd encodings:
  - 0000 ADD; 0010 SUB; 0100 AND; 0101 OR; 0110 NOR; 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL. Shift value is alu_inp1, shift amount is alu_inp2[4:0].
  - 1100 MUL. Result is the low 32 bits of the unsigned product.
  - Any other code gives alu_result = 0.
- Arithmetic: 32-bit, wrap-around. Carry and overflow are discarded.
- Non-MUL operations are combinational, with zero added latency.
- Branch resolution (combinational):
  - taken when: BEZ and alu_inp1==0; BNE and alu_inp1!=reg2; JMP always.
  - branch_addr = pc + (alu_inp2<<2), truncated to len bits. It is driven regardless of taken.
  - branch_taken is forced to 0 when flush=1, exe_stall=1 or reset=1.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: if exe_cmd==1100, flush=0 and reset=0, latch the operands, clear product and counter, and go to BUSY. exe_stall=1 combinationally in this issue cycle.
  - BUSY: each cycle, if multiplier[0] then product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. After the iteration with count==31, go to DONE. exe_stall=1 throughout.
  - DONE: exe_stall=0 and alu_result = product. Go to IDLE on the next edge. ID/EXE loads the next instruction on that same edge, so MUL is never re-issued.
- MUL timing: exe_stall is high for 33 consecutive cycles (issue + 32 BUSY). The result is presented in the 34th cycle.
- Bubbles: while exe_stall=1 or flush=1, wb_en_out, mem_read_out and mem_write_out are 0. Otherwise they equal their inputs.
- Passthroughs: reg2_out and dest_out are always passthroughs.
- Operands during a MUL are taken from the latched registers only. Input changes during BUSY are ignored.
- Reset (synchronous, any state, including mid-BUSY):
  - Next state is IDLE; product and counter are 0.
  - While reset=1: exe_stall=0, branch_taken=0, and wb_en_out, mem_read_out, mem_write_out are 0.
- flush during BUSY/DONE is ignored by the FSM: the operation completes. Downstream enables are still masked by flush.
- Back-to-back MULs: the second MUL issues in the cycle after DONE, which is IDLE with a new exe_cmd.

Test Plan:
- ADD 0x7FFFFFFF + 1, wb_en=1 -> alu_result=0x80000000, wb_en_out=1 in the same cycle, exe_stall=0.
- SRA alu_inp1=0xF0000000, alu_inp2=4 -> 0xFF000000. SRL with the same inputs -> 0x0F000000. alu_inp2=0x24 shifts by 4.
- BNE alu_inp1=5, reg2=6, pc=0x100, alu_inp2=0xFFFFFFFE -> branch_taken=1, branch_addr=0xF8. The same case with flush=1 -> branch_taken=0 and all enables 0.
- MUL 0x0001_0003 x 0x0000_0005, wb_en=1:
  - exe_stall high for exactly 33 cycles, with wb_en_out=0 throughout.
  - The next cycle gives alu_result=0x0005_000F, wb_en_out=1, exe_stall=0.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> alu_result=0x00000001. An immediately following MUL 3x4 -> 12, with a stall of 33 cycles again.
- Reset asserted on the 10th BUSY cycle -> the next cycle shows IDLE with exe_stall=0. A subsequent ADD 2+3 gives 5 with no stall.
